// File: rtl/slt_unit.sv
// Set-less-than unit: signed/unsigned 32-bit compare with a one-cycle registered result.
// Produces the MIPS-style SLT/SLTU result plus borrow and signed-less-than flags.
module slt_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        aluc,
    output logic        out_valid,
    output logic [31:0] c,
    output logic        carry,
    output logic        negative
);

    // 33-bit subtraction; bit 32 is the unsigned borrow.
    function automatic logic [32:0] sub33(input logic [31:0] x, input logic [31:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    logic [32:0] diff_s;
    logic        lt_u_s;
    logic        lt_s_s;
    logic        sel_s;
    logic        neg_s;

    logic        out_valid_r;
    logic [31:0] c_r;
    logic        carry_r;
    logic        negative_r;

    // Compare logic: when signs differ the negative operand is the smaller one.
    always_comb begin
        diff_s = sub33(a, b);
        lt_u_s = diff_s[32];
        if (a[31] != b[31]) begin
            lt_s_s = a[31];
        end else begin
            lt_s_s = lt_u_s;
        end
        if (aluc) begin
            sel_s = lt_s_s;
            neg_s = lt_s_s;
        end else begin
            sel_s = lt_u_s;
            neg_s = 1'b0;
        end
    end

    // Result register: capture on in_valid, otherwise hold data and drop out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            c_r         <= 32'h0000_0000;
            carry_r     <= 1'b0;
            negative_r  <= 1'b0;
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            c_r         <= {31'b0, sel_s};
            carry_r     <= lt_u_s;
            negative_r  <= neg_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign carry     = carry_r;
    assign negative  = negative_r;

endmodule

// File: tb/tb_slt_unit.sv
// Scoreboard bench for slt_unit: driver pushes reference results, monitor pops on out_valid.
// Covers directed corner cases, random traffic, idle hold and mid-stream reset.
module tb_slt_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        aluc;
    logic        out_valid;
    logic [31:0] c;
    logic        carry;
    logic        negative;

    typedef struct {
        logic [31:0] c;
        logic        carry;
        logic        neg;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    logic [31:0] last_c;
    logic        last_carry;
    logic        last_neg;

    slt_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .aluc     (aluc),
        .out_valid(out_valid),
        .c        (c),
        .carry    (carry),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        exp_t e;
        logic ls, lu;
        ls = ($signed(x) < $signed(y));
        lu = (x < y);
        e.c     = sgn ? 32'(ls) : 32'(lu);
        e.carry = lu;
        e.neg   = sgn ? ls : 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sgn, input logic v);
        @(negedge clk);
        a        = x;
        b        = y;
        aluc     = sgn;
        in_valid = v;
        if (v) sb.push_back(model(x, y, sgn));
    endtask

    // Monitor: pop and compare on every out_valid, otherwise confirm outputs held.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("c", c, e.c);
                    check("carry", 32'(carry), 32'(e.carry));
                    check("negative", 32'(negative), 32'(e.neg));
                    last_c     = e.c;
                    last_carry = e.carry;
                    last_neg   = e.neg;
                end
            end else begin
                check("hold_c", c, last_c);
                check("hold_flags", {30'd0, carry, negative}, {30'd0, last_carry, last_neg});
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        tests = 0;
        fails = 0;
        last_c = 32'd0;
        last_carry = 1'b0;
        last_neg = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = 32'd0;
        b = 32'd0;
        aluc = 1'b0;
        #3;
        check("reset_c", c, 32'd0);
        check("reset_flags", {29'd0, out_valid, carry, negative}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        issue(32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b1);
        issue(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
        issue(32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

        // Random traffic with sporadic idles and some equal operands
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 5) == 0) rb[31] = ~ra[31];
            issue(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        // Back-to-back, alternating mode, then idle hold
        for (int i = 0; i < 4; i++) issue($urandom, $urandom, 1'(i % 2), 1'b1);
        repeat (3) issue(32'h0000_0005, 32'h0000_0009, 1'b0, 1'b0);

        // Reset mid-stream discards in-flight operations
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_c", c, 32'd0);
        check("midrst_flags", {29'd0, out_valid, carry, negative}, 32'd0);
        sb.delete();
        last_c = 32'd0;
        last_carry = 1'b0;
        last_neg = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        issue(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0);
        issue(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0);
        issue(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 1'b1);
        issue(32'h0000_0010, 32'hFFFF_FFF0, 1'b0, 1'b1);
        repeat (3) issue(32'd0, 32'd0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
